// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh: raises aref_req each CNT_REF_MAX cycles, then on grant runs PRE + AR_NUM x AR.
// Latency: PRE one cycle after grant, aref_end on the last burst cycle; a pending request stays raised until granted.
module sdram_aref #(
    parameter int CNT_REF_MAX = 750,
    parameter int TRP_CYC     = 2,
    parameter int TRFC_CYC    = 7,
    parameter int AR_NUM      = 2
) (
    input  logic        init_clk,
    input  logic        init_rst_n,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic        aref_end,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_bank,
    output logic [12:0] aref_addr
);

    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam logic [9:0] REF_LAST  = 10'(CNT_REF_MAX - 1);
    localparam logic [3:0] TRP_LAST  = 4'(TRP_CYC - 1);
    localparam logic [3:0] TRFC_LAST = 4'(TRFC_CYC - 1);
    localparam logic [3:0] AR_TOTAL  = 4'(AR_NUM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_TRP,
        ST_AR,
        ST_TRFC,
        ST_END
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_ref_q, cnt_ref_d;
    logic [3:0]  cnt_fsm_q, cnt_fsm_d;
    logic [3:0]  cnt_ar_q, cnt_ar_d;
    logic        aref_req_q, aref_req_d;

    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_ref_q  <= '0;
            cnt_fsm_q  <= '0;
            cnt_ar_q   <= '0;
            aref_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_ref_q  <= cnt_ref_d;
            cnt_fsm_q  <= cnt_fsm_d;
            cnt_ar_q   <= cnt_ar_d;
            aref_req_q <= aref_req_d;
        end
    end

    // Period counter keeps running through a burst; a wrap during PRE re-arms the request.
    always_comb begin
        cnt_ref_d  = cnt_ref_q + 10'd1;
        aref_req_d = aref_req_q;
        if (cnt_ref_q == REF_LAST) begin
            cnt_ref_d = '0;
        end
        if (state_q == ST_PRE) begin
            aref_req_d = 1'b0;
        end
        if (cnt_ref_q == REF_LAST) begin
            aref_req_d = 1'b1;
        end
        if (!init_end) begin
            cnt_ref_d  = '0;
            aref_req_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_fsm_d = '0;
        cnt_ar_d  = cnt_ar_q;
        aref_cmd  = CMD_NOP;
        aref_end  = 1'b0;
        aref_bank = 2'b11;
        aref_addr = 13'h1fff;
        case (state_q)
            ST_IDLE: begin
                if (aref_req_q && aref_en) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                aref_cmd = CMD_PRE;
                state_d  = ST_TRP;
            end
            ST_TRP: begin
                if (cnt_fsm_q == TRP_LAST) begin
                    state_d = ST_AR;
                end else begin
                    cnt_fsm_d = cnt_fsm_q + 4'd1;
                end
            end
            ST_AR: begin
                aref_cmd = CMD_AR;
                cnt_ar_d = cnt_ar_q + 4'd1;
                state_d  = ST_TRFC;
            end
            ST_TRFC: begin
                if (cnt_fsm_q == TRFC_LAST) begin
                    state_d = (cnt_ar_q == AR_TOTAL) ? ST_END : ST_AR;
                end else begin
                    cnt_fsm_d = cnt_fsm_q + 4'd1;
                end
            end
            ST_END: begin
                aref_end = 1'b1;
                cnt_ar_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Re-initialisation abandons any burst in progress.
        if (!init_end) begin
            state_d   = ST_IDLE;
            cnt_fsm_d = '0;
            cnt_ar_d  = '0;
        end
    end

    assign aref_req = aref_req_q;

endmodule
